// File: rtl/zone_tracker_pkg.sv
// Shared geometry defaults and elaboration-time helpers for the zone tracker.
package zone_tracker_pkg;

    localparam int DEF_SCREEN_WIDTH  = 1280;
    localparam int DEF_SCREEN_HEIGHT = 720;
    localparam int DEF_COLS          = 4;
    localparam int DEF_ROWS          = 2;
    localparam int DEF_COORD_W       = 12;
    localparam int DEF_STABLE_FRAMES = 3;

    // Streak counter is wide enough for the largest legal STABLE_FRAMES (255).
    localparam int CNT_W = 8;

    // Ceiling log2 for constant expressions.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int v);
        return (clog2(v) < 1) ? 1 : clog2(v);
    endfunction

endpackage

// File: rtl/axis_quantizer.sv
// Maps one coordinate to a grid index using constant thresholds floor(c*LEN/DIV).
module axis_quantizer
    import zone_tracker_pkg::*;
#(
    parameter int LEN     = DEF_SCREEN_WIDTH,
    parameter int DIV     = DEF_COLS,
    parameter int COORD_W = DEF_COORD_W,
    localparam int IDX_W  = clog2_min1(DIV)
) (
    input  logic [COORD_W-1:0] coord_i,
    output logic [IDX_W-1:0]   idx_o
);

    logic [31:0] coord_ext;
    assign coord_ext = 32'(coord_i);

    // Comparator chain: the highest threshold crossed wins; thresholds fold to constants.
    always_comb begin
        idx_o = '0;
        for (int c = 1; c < DIV; c++) begin
            if (coord_ext >= 32'((c * LEN) / DIV)) idx_o = IDX_W'(c);
        end
    end

endmodule

// File: rtl/zone_tracker.sv
// Centroid-to-zone tracker: stage 1 quantizes each sample to a raw zone,
// stage 2 debounces raw zones and commits a zone after a stable streak.
module zone_tracker
    import zone_tracker_pkg::*;
#(
    parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
    parameter int COLS          = DEF_COLS,
    parameter int ROWS          = DEF_ROWS,
    parameter int COORD_W       = DEF_COORD_W,
    parameter int STABLE_FRAMES = DEF_STABLE_FRAMES,
    localparam int ZONE_W       = clog2_min1(COLS * ROWS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] x_avg,
    input  logic [COORD_W-1:0] y_avg,
    input  logic               coord_valid,
    output logic [ZONE_W-1:0]  raw_zone,
    output logic               raw_valid,
    output logic               out_of_range,
    output logic [ZONE_W-1:0]  zone,
    output logic               zone_valid,
    output logic               zone_changed
);

    localparam int COL_W = clog2_min1(COLS);
    localparam int ROW_W = clog2_min1(ROWS);
    localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_FRAMES);

    logic [COL_W-1:0]  col_idx;
    logic [ROW_W-1:0]  row_idx;
    logic [ZONE_W-1:0] zone_calc;
    logic              in_range;

    // Stage 1 state
    logic [ZONE_W-1:0] raw_zone_q, raw_zone_d;
    logic              raw_valid_q, raw_valid_d;
    logic              oor_q, oor_d;

    // Stage 2 state
    logic [ZONE_W-1:0] cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ZONE_W-1:0] zone_q, zone_d;
    logic              zone_valid_q, zone_valid_d;
    logic              zone_changed_q, zone_changed_d;

    axis_quantizer #(.LEN(SCREEN_WIDTH), .DIV(COLS), .COORD_W(COORD_W)) u_xq (
        .coord_i (x_avg),
        .idx_o   (col_idx)
    );

    axis_quantizer #(.LEN(SCREEN_HEIGHT), .DIV(ROWS), .COORD_W(COORD_W)) u_yq (
        .coord_i (y_avg),
        .idx_o   (row_idx)
    );

    assign in_range  = (32'(x_avg) < 32'(SCREEN_WIDTH)) && (32'(y_avg) < 32'(SCREEN_HEIGHT));
    assign zone_calc = ZONE_W'(row_idx) * ZONE_W'(COLS) + ZONE_W'(col_idx);

    // Stage 1: latch the raw zone for in-range samples, flag the rest as out of range.
    always_comb begin
        raw_zone_d  = raw_zone_q;
        raw_valid_d = 1'b0;
        oor_d       = 1'b0;
        if (coord_valid) begin
            if (in_range) begin
                raw_zone_d  = zone_calc;
                raw_valid_d = 1'b1;
            end else begin
                oor_d = 1'b1;
            end
        end
    end

    // Stage 2: extend or restart the streak, commit when it reaches STABLE_FRAMES.
    always_comb begin
        cand_d         = cand_q;
        cnt_d          = cnt_q;
        zone_d         = zone_q;
        zone_valid_d   = zone_valid_q;
        zone_changed_d = 1'b0;
        if (oor_q) begin
            // An out-of-range frame breaks the streak but keeps the candidate.
            cnt_d = '0;
        end else if (raw_valid_q) begin
            if (raw_zone_q == cand_q && cnt_q != '0) begin
                cnt_d = (cnt_q < STABLE) ? cnt_q + CNT_W'(1) : cnt_q;
            end else begin
                cand_d = raw_zone_q;
                cnt_d  = CNT_W'(1);
            end
            // A saturated streak on the committed zone must not re-pulse.
            if (cnt_d == STABLE && (cand_d != zone_q || !zone_valid_q)) begin
                zone_d         = cand_d;
                zone_valid_d   = 1'b1;
                zone_changed_d = 1'b1;
            end
        end
    end

    // Pipeline registers; reset drops any sample in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_zone_q     <= '0;
            raw_valid_q    <= 1'b0;
            oor_q          <= 1'b0;
            cand_q         <= '0;
            cnt_q          <= '0;
            zone_q         <= '0;
            zone_valid_q   <= 1'b0;
            zone_changed_q <= 1'b0;
        end else begin
            raw_zone_q     <= raw_zone_d;
            raw_valid_q    <= raw_valid_d;
            oor_q          <= oor_d;
            cand_q         <= cand_d;
            cnt_q          <= cnt_d;
            zone_q         <= zone_d;
            zone_valid_q   <= zone_valid_d;
            zone_changed_q <= zone_changed_d;
        end
    end

    assign raw_zone     = raw_zone_q;
    assign raw_valid    = raw_valid_q;
    assign out_of_range = oor_q;
    assign zone         = zone_q;
    assign zone_valid   = zone_valid_q;
    assign zone_changed = zone_changed_q;

endmodule

// File: tb/tb_zone_tracker.sv
// Scoreboard bench for zone_tracker: default-geometry instance checked every
// cycle against queued expectations, plus a 3x3 single-frame instance.
module tb_zone_tracker;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Default instance
    logic [11:0] x_avg, y_avg;
    logic        coord_valid;
    logic [2:0]  raw_zone, zone;
    logic        raw_valid, out_of_range, zone_valid, zone_changed;

    // 3x3, STABLE_FRAMES=1 instance
    logic [11:0] x2, y2;
    logic        v2;
    logic [3:0]  raw_zone2, zone2;
    logic        raw_valid2, oor2, zone_valid2, zone_changed2;

    zone_tracker dut (
        .clk(clk), .rst(rst), .x_avg(x_avg), .y_avg(y_avg), .coord_valid(coord_valid),
        .raw_zone(raw_zone), .raw_valid(raw_valid), .out_of_range(out_of_range),
        .zone(zone), .zone_valid(zone_valid), .zone_changed(zone_changed)
    );

    zone_tracker #(.COLS(3), .ROWS(3), .STABLE_FRAMES(1)) dut2 (
        .clk(clk), .rst(rst), .x_avg(x2), .y_avg(y2), .coord_valid(v2),
        .raw_zone(raw_zone2), .raw_valid(raw_valid2), .out_of_range(oor2),
        .zone(zone2), .zone_valid(zone_valid2), .zone_changed(zone_changed2)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int         due;
        logic [2:0] raw;
        logic       oor;
        logic       chg;
        logic [2:0] zn;
        logic       zv;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    // Reference state for the default instance
    logic [2:0] m_raw, m_cand, m_zone;
    int         m_cnt;
    logic       m_zv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_raw = 0; m_cand = 0; m_zone = 0; m_cnt = 0; m_zv = 0;
    endtask

    // Drive one strobe on the default instance and queue what it must produce.
    task automatic drive(input int x, input int y, input bit wait_edge = 1'b1);
        exp_t e;
        if (wait_edge) begin
            @(posedge clk); #1;
        end
        coord_valid = 1'b1;
        x_avg = 12'(x);
        y_avg = 12'(y);
        e.due = cyc + 1;
        if (x >= 1280 || y >= 720) begin
            m_cnt = 0;
            e.oor = 1'b1;
            e.chg = 1'b0;
        end else begin
            m_raw = 3'((y / 360) * 4 + x / 320);
            if (m_raw == m_cand && m_cnt > 0) begin
                if (m_cnt < 3) m_cnt++;
            end else begin
                m_cand = m_raw;
                m_cnt  = 1;
            end
            e.oor = 1'b0;
            e.chg = (m_cnt == 3) && (m_cand != m_zone || !m_zv);
            if (e.chg) begin
                m_zone = m_cand;
                m_zv   = 1'b1;
            end
        end
        e.raw = m_raw;
        e.zn  = m_zone;
        e.zv  = m_zv;
        q1.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            coord_valid = 1'b0;
        end
    endtask

    // Leaves rst deasserted #1 after a rising edge, so the next edge is the first one out of reset.
    task automatic do_reset();
        @(posedge clk); #1;
        coord_valid = 1'b0;
        q1.delete();
        q2.delete();
        rst = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle scoreboard for the default instance.
    always @(negedge clk) begin : scoreboard
        exp_t e;
        if (rst) begin
            chk("rst_raw_zone", 32'(raw_zone), 0);
            chk("rst_raw_valid", 32'(raw_valid), 0);
            chk("rst_oor", 32'(out_of_range), 0);
            chk("rst_zone", 32'(zone), 0);
            chk("rst_zone_valid", 32'(zone_valid), 0);
            chk("rst_zone_changed", 32'(zone_changed), 0);
        end else begin
            if (q1.size() > 0 && q1[0].due == cyc) begin
                e = q1.pop_front();
                chk("s1_raw_valid", 32'(raw_valid), 32'(!e.oor));
                chk("s1_oor", 32'(out_of_range), 32'(e.oor));
                chk("s1_raw_zone", 32'(raw_zone), 32'(e.raw));
                e.due = e.due + 1;
                q2.push_back(e);
            end else begin
                chk("idle_raw_valid", 32'(raw_valid), 0);
                chk("idle_oor", 32'(out_of_range), 0);
            end
            if (q2.size() > 0 && q2[0].due == cyc) begin
                e = q2.pop_front();
                chk("s2_zone_changed", 32'(zone_changed), 32'(e.chg));
                chk("s2_zone", 32'(zone), 32'(e.zn));
                chk("s2_zone_valid", 32'(zone_valid), 32'(e.zv));
            end else begin
                chk("idle_zone_changed", 32'(zone_changed), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        coord_valid = 1'b0; x_avg = '0; y_avg = '0;
        v2 = 1'b0; x2 = '0; y2 = '0;
        model_clear();
        #2 rst = 1'b1;
        do_reset();

        // Three spaced frames at zone 0; first strobe lands on the first edge out of reset.
        drive(100, 100, 1'b0); idle(2);
        drive(100, 100);       idle(2);
        drive(100, 100);       idle(3);
        chk("commit0_zone", 32'(zone), 0);
        chk("commit0_valid", 32'(zone_valid), 1);

        // A single stray frame, then a return streak on the committed zone.
        drive(1000, 500); idle(1);
        drive(100, 100);  idle(1);
        drive(100, 100);  idle(1);
        drive(100, 100);  idle(3);
        chk("stray_zone", 32'(zone), 0);

        // Grid boundaries.
        drive(319, 359);  idle(1);
        drive(320, 360);  idle(1);
        drive(959, 0);    idle(1);
        drive(1279, 719); idle(3);

        // Out-of-range breaks a streak; back-to-back strobes afterwards.
        drive(1000, 100); idle(1);
        drive(1000, 100); idle(1);
        drive(1280, 10);  idle(1);
        drive(1000, 100);
        drive(1000, 100);
        drive(10, 720);
        drive(1000, 100);
        drive(1000, 100);
        drive(1000, 100);
        idle(4);
        chk("streak_zone", 32'(zone), 3);

        // Reset one cycle after the third identical strobe.
        do_reset();
        drive(100, 100, 1'b0);
        drive(100, 100);
        drive(100, 100);
        do_reset();
        idle(5);
        chk("rstmid_zone_valid", 32'(zone_valid), 0);
        chk("rstmid_zone", 32'(zone), 0);
        chk("rstmid_raw_zone", 32'(raw_zone), 0);

        // 3x3 grid, single-frame commit, back-to-back strobes.
        chk("g3_pre_valid", 32'(zone_valid2), 0);
        @(posedge clk); #1; v2 = 1'b1; x2 = 12'd0;    y2 = 12'd0;
        @(posedge clk); #1; x2 = 12'd1279; y2 = 12'd719;
        @(posedge clk); #1; x2 = 12'd640;  y2 = 12'd360;
        @(negedge clk);
        chk("g3_a_changed", 32'(zone_changed2), 1);
        chk("g3_a_zone", 32'(zone2), 0);
        chk("g3_a_valid", 32'(zone_valid2), 1);
        chk("g3_a_raw", 32'(raw_zone2), 8);
        @(posedge clk); #1; v2 = 1'b0;
        @(negedge clk);
        chk("g3_b_changed", 32'(zone_changed2), 1);
        chk("g3_b_zone", 32'(zone2), 8);
        chk("g3_b_raw", 32'(raw_zone2), 4);
        chk("g3_b_raw_valid", 32'(raw_valid2), 1);
        @(negedge clk);
        chk("g3_c_changed", 32'(zone_changed2), 1);
        chk("g3_c_zone", 32'(zone2), 4);
        chk("g3_c_raw_valid", 32'(raw_valid2), 0);
        chk("g3_c_oor", 32'(oor2), 0);
        @(negedge clk);
        chk("g3_quiet_changed", 32'(zone_changed2), 0);

        idle(3);
        chk("queue1_drained", 32'(q1.size()), 0);
        chk("queue2_drained", 32'(q2.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
